button_cmd_decoder: RTL and testbench
=====================================

// Module: button_cmd_decoder
// PURPOSE
//   Input-side counterpart of the LED output path: turns the raw io_button[4:0] shield buttons into clean game commands for game_loop.
//   Per button: synchronise, debounce, detect press edges.
//   Direction presses are queued in a small FIFO and handed over with a valid/ready handshake.
//   A centre press produces a one-cycle game reset pulse and flushes the queue.
// PARAMETERS
//   DEBOUNCE_CYCLES  1000000  cycles an input must hold a new level before it is accepted (20 ms at 50 MHz); sims use 8
//   CNT_W            20       debounce counter width; must satisfy 2**CNT_W >= DEBOUNCE_CYCLES
//   FIFO_DEPTH       4        command queue entries, power of two, >= 2
// PORTS
//   clk        in   1  50 MHz system clock
//   rst_n      in   1  asynchronous, active-low reset
//   io_button  in   5  raw buttons, active high; [0] up, [1] centre, [2] down, [3] left, [4] right
//   cmd_valid  out  1  queue head holds a command
//   cmd_ready  in   1  consumer accepts the head this cycle
//   cmd_dir    out  2  head direction: 0 up, 1 down, 2 left, 3 right
//   game_rst   out  1  one-cycle pulse on a debounced centre press
//   drop_cnt   out  8  saturating count of discarded direction presses
// BEHAVIOUR
//   - Reset (async assert, sync release) clears everything:
//     - cmd_valid=0, cmd_dir=0, game_rst=0, drop_cnt=0.
//     - Synchronisers, stable levels and edge regs = 0; counters = 0; FIFO empty.
//   - Sync: each bit passes a 2-FF synchroniser before any use.
//   - Debounce, per bit:
//     - sync == stable: counter <= 0.
//     - sync != stable: counter increments.
//     - On the cycle counter == DEBOUNCE_CYCLES-1: stable <= sync and counter <= 0.
//     - A glitch shorter than DEBOUNCE_CYCLES restarts the count and never changes stable.
//   - Edge: press = stable & ~stable_d, registered (1 cycle). Releases generate nothing.
//   - Latency: raw rise at edge t, held steady:
//     - press pulse at t+3+DEBOUNCE_CYCLES.
//     - For a direction into an empty FIFO, cmd_valid=1 at t+4+DEBOUNCE_CYCLES.
//     - game_rst follows the same timing as the press pulse stage plus 1 (registered).
//   - Direction arbitration when several press pulses fall in the same cycle:
//     - Priority up > down > left > right. Only the winner is pushed.
//     - Each loser increments drop_cnt (+1 per loser, saturating at 255).
//   - FIFO:
//     - push = winning press; pop = cmd_valid & cmd_ready.
//     - cmd_valid/cmd_dir come straight from the head register; no combinational path from cmd_ready to cmd_valid.
//     - Full, push without pop: press discarded, drop_cnt +1.
//     - Full, push and pop in the same cycle: both happen, nothing dropped, occupancy unchanged.
//     - Empty, push: cmd_valid rises the next cycle (no fall-through within the same cycle).
//     - cmd_ready while empty has no effect.
//     - Pointers wrap modulo FIFO_DEPTH. A separate count (log2(DEPTH)+1 bits) distinguishes full from empty.
//   - Centre press:
//     - game_rst=1 for exactly 1 cycle.
//     - The FIFO is flushed the same cycle (cmd_valid=0 the next cycle).
//     - A direction press in the same cycle is discarded and not counted.
//     - drop_cnt is not cleared (only rst_n clears it).
//   - Holding a button gives one command only; no auto-repeat.
//   - rst_n asserted mid-debounce or with the FIFO non-empty: all state cleared at once.
//     - A button still held after release becomes a fresh press once it has been stable for DEBOUNCE_CYCLES.
// STRUCTURE
//   - game_pkg (shared with game_loop):
//     - DIR_UP/DIR_DOWN/DIR_LEFT/DIR_RIGHT 2-bit constants.
//     - BTN_UP=0, BTN_CENTRE=1, BTN_DOWN=2, BTN_LEFT=3, BTN_RIGHT=4 index constants.
//   - Sub-module button_debouncer (sync + counter + stable + press pulse):
//     - Parameters DEBOUNCE_CYCLES and CNT_W; instantiated 5 times.
//   - Arbitration, FIFO and drop counter stay in this module.
// TESTING (DEBOUNCE_CYCLES=8, FIFO_DEPTH=4)
//   - Single press: hold io_button[4] high for 20 cycles, cmd_ready=1.
//     -> exactly one cmd_valid cycle with cmd_dir=3, at t+12; drop_cnt=0.
//   - Bounce: toggle io_button[0] every 3 cycles 5 times, then hold high.
//     -> exactly one cmd_dir=0, 12 cycles after the final rise.
//   - Overflow: cmd_ready=0, press down 6 separate times.
//     -> 4 entries, all dir=1; drop_cnt=2.
//     -> Then raise cmd_ready: exactly 4 pops, cmd_valid=0 afterwards.
//   - Simultaneous: raise io_button[0] and io_button[3] in the same cycle.
//     -> one cmd_dir=0; drop_cnt=1.
//   - Centre flush: queue 3 commands, then press centre.
//     -> one game_rst pulse; cmd_valid=0 the next cycle; drop_cnt unchanged.
//   - Reset mid-run: assert rst_n=0 with 2 queued commands and a debounce in flight.
//     -> all outputs 0 at once; no command appears after release until a new stable press.

Source files
------------

// File: rtl/button_cmd_decoder_pkg.sv
// Shared game-side constants for the button command path.
//   DIR_*  : 2-bit command directions handed to game_loop.
//   BTN_*  : bit positions of the shield buttons on io_button.
// The helpers operate on a 4-bit direction vector ordered so that the bit
// index equals the DIR_* code: [0] up, [1] down, [2] left, [3] right.
package button_cmd_decoder_pkg;

  localparam logic [1:0] DIR_UP    = 2'd0;
  localparam logic [1:0] DIR_DOWN  = 2'd1;
  localparam logic [1:0] DIR_LEFT  = 2'd2;
  localparam logic [1:0] DIR_RIGHT = 2'd3;

  localparam int BTN_UP     = 0;
  localparam int BTN_CENTRE = 1;
  localparam int BTN_DOWN   = 2;
  localparam int BTN_LEFT   = 3;
  localparam int BTN_RIGHT  = 4;
  localparam int NUM_BTN    = 5;

  typedef struct packed {
    logic       vld;
    logic [1:0] dir;
  } dir_req_t;

  // Lowest set bit wins, i.e. up > down > left > right.
  function automatic dir_req_t arbitrate(input logic [3:0] dirs);
    dir_req_t r;
    r.vld = |dirs;
    if (dirs[0])      r.dir = DIR_UP;
    else if (dirs[1]) r.dir = DIR_DOWN;
    else if (dirs[2]) r.dir = DIR_LEFT;
    else              r.dir = DIR_RIGHT;
    return r;
  endfunction

  function automatic logic [2:0] dir_count(input logic [3:0] dirs);
    return 3'(dirs[0]) + 3'(dirs[1]) + 3'(dirs[2]) + 3'(dirs[3]);
  endfunction

endpackage

// File: rtl/button_cmd_decoder_if.sv
// Command handshake between the button decoder (master) and game_loop (slave).
//   cmd_valid : head of the command queue holds a direction
//   cmd_ready : consumer takes the head this cycle
//   cmd_dir   : head direction (DIR_* code)
interface button_cmd_decoder_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_dir;

  modport master (output cmd_valid, output cmd_dir, input cmd_ready);
  modport slave  (input cmd_valid, input cmd_dir, output cmd_ready);
endinterface

// File: rtl/button_cmd_decoder_debouncer.sv
// One button lane: 2-FF synchroniser, debounce counter, stable level and a
// registered one-cycle press pulse (rising edge of the stable level).
//   clk, rst_n : clock, async active-low reset
//   i_raw      : raw asynchronous button level
//   o_press    : one-cycle pulse per accepted press; releases give nothing
module button_debouncer #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_W           = 20
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_raw,
  output logic o_press
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             r_sync1, r_sync2;
  logic             r_stable, r_stable_d;
  logic             r_press;
  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1    <= 1'b0;
      r_sync2    <= 1'b0;
      r_stable   <= 1'b0;
      r_stable_d <= 1'b0;
      r_press    <= 1'b0;
      r_cnt      <= '0;
    end else begin
      r_sync1    <= i_raw;
      r_sync2    <= r_sync1;
      r_stable_d <= r_stable;
      r_press    <= r_stable & ~r_stable_d;
      // Any sample agreeing with the stable level restarts the count, so a
      // glitch shorter than DEBOUNCE_CYCLES can never flip r_stable.
      if (r_sync2 == r_stable) begin
        r_cnt <= '0;
      end else if (r_cnt == CNT_LAST) begin
        r_stable <= r_sync2;
        r_cnt    <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign o_press = r_press;

endmodule

// File: rtl/button_cmd_decoder.sv
// Turns the raw shield buttons into game commands.
//   clk, rst_n : 50 MHz clock, async active-low reset
//   io_button  : raw buttons [0] up [1] centre [2] down [3] left [4] right
//   cmd        : master side of the valid/ready direction queue
//   game_rst   : one-cycle pulse on a debounced centre press
//   drop_cnt   : saturating count of discarded direction presses
// Same-cycle direction presses are arbitrated (up > down > left > right),
// the winner goes into a FIFO_DEPTH queue, losers and full-queue pushes are
// counted as drops. A centre press flushes the queue and suppresses any
// direction press landing in the same cycle.
module button_cmd_decoder
  import button_cmd_decoder_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_W           = 20,
  parameter int FIFO_DEPTH      = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_BTN-1:0]   io_button,
  button_cmd_decoder_if.master cmd,
  output logic                 game_rst,
  output logic [7:0]           drop_cnt
);

  localparam int               PTR_W    = $clog2(FIFO_DEPTH);
  localparam logic [PTR_W:0]   FULL_CNT = (PTR_W + 1)'(FIFO_DEPTH);

  logic [NUM_BTN-1:0] w_press;
  logic [3:0]         w_dirs;
  dir_req_t           w_req;
  logic               w_centre, w_pop, w_push, w_full;
  logic [2:0]         w_drop_inc;
  logic [8:0]         w_drop_sum;
  logic [PTR_W-1:0]   w_rd_nxt, w_wr_nxt;
  logic [PTR_W:0]     w_cnt_nxt;
  logic [1:0]         w_dir_nxt;

  logic [1:0]         r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   r_rd_ptr, r_wr_ptr;
  logic [PTR_W:0]     r_count;
  logic               r_cmd_valid;
  logic [1:0]         r_cmd_dir;
  logic               r_game_rst;
  logic [7:0]         r_drop;

  genvar g;
  generate
    for (g = 0; g < NUM_BTN; g++) begin : g_btn
      button_debouncer #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_W           (CNT_W)
      ) u_deb (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_raw   (io_button[g]),
        .o_press (w_press[g])
      );
    end
  endgenerate

  // Reorder so the bit index equals the DIR_* code.
  assign w_dirs = {w_press[BTN_RIGHT], w_press[BTN_LEFT],
                   w_press[BTN_DOWN],  w_press[BTN_UP]};

  always_comb begin
    w_req    = arbitrate(w_dirs);
    w_centre = w_press[BTN_CENTRE];
    // r_cmd_valid mirrors (r_count != 0); using the register keeps pop off
    // any long path and makes ready-while-empty a no-op.
    w_pop    = r_cmd_valid & cmd.cmd_ready;
    w_full   = (r_count == FULL_CNT);
    // Full with a simultaneous pop still accepts the push.
    w_push   = w_req.vld & ~w_centre & (~w_full | w_pop);

    w_drop_inc = '0;
    if (w_req.vld && !w_centre)
      w_drop_inc = dir_count(w_dirs) - 3'd1 + {2'b00, w_full & ~w_pop};
    w_drop_sum = {1'b0, r_drop} + {6'b0, w_drop_inc};

    w_rd_nxt  = r_rd_ptr + PTR_W'(w_pop);
    w_wr_nxt  = r_wr_ptr + PTR_W'(w_push);
    w_cnt_nxt = r_count + (PTR_W + 1)'(w_push) - (PTR_W + 1)'(w_pop);

    // Next head: if the slot being written becomes the head, take the new
    // direction directly since r_mem is not updated until this edge.
    w_dir_nxt = r_cmd_dir;
    if (w_cnt_nxt != '0)
      w_dir_nxt = (w_push && (r_wr_ptr == w_rd_nxt)) ? w_req.dir : r_mem[w_rd_nxt];
  end

  // Storage needs no reset: occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= w_req.dir;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_ptr    <= '0;
      r_wr_ptr    <= '0;
      r_count     <= '0;
      r_cmd_valid <= 1'b0;
      r_cmd_dir   <= DIR_UP;
      r_game_rst  <= 1'b0;
      r_drop      <= '0;
    end else begin
      r_game_rst <= w_centre;
      r_drop     <= w_drop_sum[8] ? 8'hFF : w_drop_sum[7:0];
      if (w_centre) begin
        r_rd_ptr    <= '0;
        r_wr_ptr    <= '0;
        r_count     <= '0;
        r_cmd_valid <= 1'b0;
      end else begin
        r_rd_ptr    <= w_rd_nxt;
        r_wr_ptr    <= w_wr_nxt;
        r_count     <= w_cnt_nxt;
        r_cmd_valid <= (w_cnt_nxt != '0);
        r_cmd_dir   <= w_dir_nxt;
      end
    end
  end

  assign cmd.cmd_valid = r_cmd_valid;
  assign cmd.cmd_dir   = r_cmd_dir;
  assign game_rst      = r_game_rst;
  assign drop_cnt      = r_drop;

endmodule

// File: tb/tb_button_cmd_decoder.sv
module tb_button_cmd_decoder;
  import button_cmd_decoder_pkg::*;

  localparam int D     = 8;
  localparam int DEPTH = 4;
  localparam int PRIO [4] = '{BTN_UP, BTN_DOWN, BTN_LEFT, BTN_RIGHT};

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [4:0] io_button = '0;
  logic       game_rst;
  logic [7:0] drop_cnt;

  button_cmd_decoder_if bus ();

  button_cmd_decoder #(
    .DEBOUNCE_CYCLES (D),
    .CNT_W           (4),
    .FIFO_DEPTH      (DEPTH)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .io_button (io_button),
    .cmd       (bus),
    .game_rst  (game_rst),
    .drop_cnt  (drop_cnt)
  );

  always #5 clk = ~clk;

  // Reference model: raw samples delayed two edges, a run length of samples
  // disagreeing with the accepted level, press events acting two edges after
  // acceptance, and a plain queue for the command FIFO.
  logic [4:0] hist [$];
  int         run [5];
  bit         acc [5];
  logic [4:0] pend0, pend1;
  logic [1:0] q [$];
  int         m_drop;
  bit         m_grst;

  int n_cmp = 0, n_err = 0;
  int tk = 0, n_hs = 0, n_grst = 0, n_rise = 0, last_rise = 0;
  bit prev_v = 1'b0;
  logic [1:0] hs_dir = '0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic m_reset();
    hist.delete();
    for (int i = 0; i < 5; i++) begin run[i] = 0; acc[i] = 1'b0; end
    pend0 = '0; pend1 = '0;
    q.delete();
    m_drop = 0; m_grst = 1'b0;
  endtask

  task automatic m_step(input logic [4:0] b, input logic rdy);
    logic [4:0] act, flips, seen;
    bit pop;
    int nd, win;
    act = pend1; pend1 = pend0; flips = '0;
    hist.push_back(b);
    if (hist.size() > 3) void'(hist.pop_front());
    seen = (hist.size() == 3) ? hist[0] : 5'b0;
    for (int i = 0; i < 5; i++) begin
      if (seen[i] != acc[i]) begin
        run[i]++;
        if (run[i] == D) begin
          acc[i] = seen[i]; run[i] = 0; flips[i] = seen[i];
        end
      end else run[i] = 0;
    end
    pend0 = flips;
    pop = (q.size() != 0) && rdy;
    m_grst = act[BTN_CENTRE];
    if (act[BTN_CENTRE]) q.delete();
    else begin
      nd = 0; win = -1;
      for (int k = 0; k < 4; k++)
        if (act[PRIO[k]]) begin nd++; if (win < 0) win = k; end
      if (pop) void'(q.pop_front());
      if (win >= 0) begin
        m_drop += nd - 1;
        if (q.size() < DEPTH) q.push_back(2'(win));
        else m_drop++;
      end
      if (m_drop > 255) m_drop = 255;
    end
  endtask

  task automatic tick(input logic [4:0] b, input logic rdy);
    bit hs;
    tk++;
    io_button = b;
    bus.cmd_ready = rdy;
    hs = bus.cmd_valid && rdy;
    if (hs) begin n_hs++; hs_dir = bus.cmd_dir; end
    @(posedge clk);
    m_step(b, rdy);
    #1;
    chk("cmd_valid", bus.cmd_valid, (q.size() != 0));
    if (q.size() != 0) chk("cmd_dir", bus.cmd_dir, q[0]);
    chk("game_rst", game_rst, m_grst);
    chk("drop_cnt", drop_cnt, m_drop);
    if (game_rst) n_grst++;
    if (bus.cmd_valid && !prev_v) begin n_rise++; last_rise = tk; end
    prev_v = bus.cmd_valid;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_valid", bus.cmd_valid, 0);
    chk("rst_dir", bus.cmd_dir, 0);
    chk("rst_game_rst", game_rst, 0);
    chk("rst_drop", drop_cnt, 0);
    m_reset();
    prev_v = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic press(input logic [4:0] b, input int hi, input int lo, input logic rdy);
    repeat (hi) tick(b, rdy);
    repeat (lo) tick(5'b0, rdy);
  endtask

  int tk0;

  initial begin
    bus.cmd_ready = 1'b0;
    #2;
    do_reset();

    // Single press of right, ready held high.
    tk0 = tk; n_hs = 0;
    press(5'b10000, 20, 15, 1'b1);
    chk("single_latency", last_rise - tk0, 12);
    chk("single_pops", n_hs, 1);
    chk("single_dir", hs_dir, 3);
    chk("single_drop", drop_cnt, 0);

    // Bouncing up button, then held.
    n_hs = 0;
    repeat (3) tick(5'b00001, 1'b1);
    repeat (3) tick(5'b00000, 1'b1);
    repeat (3) tick(5'b00001, 1'b1);
    repeat (3) tick(5'b00000, 1'b1);
    tk0 = tk;
    press(5'b00001, 20, 14, 1'b1);
    chk("bounce_latency", last_rise - tk0, 12);
    chk("bounce_pops", n_hs, 1);
    chk("bounce_dir", hs_dir, 0);

    // Overflow: six down presses into a stalled queue.
    repeat (6) press(5'b00100, 14, 14, 1'b0);
    chk("ovf_drop", drop_cnt, 2);
    chk("ovf_valid", bus.cmd_valid, 1);
    n_hs = 0;
    repeat (10) tick(5'b0, 1'b1);
    chk("ovf_pops", n_hs, 4);
    chk("ovf_dir", hs_dir, 1);
    chk("ovf_empty", bus.cmd_valid, 0);

    // Up and left in the same cycle.
    n_hs = 0;
    press(5'b01001, 20, 14, 1'b1);
    chk("simul_pops", n_hs, 1);
    chk("simul_dir", hs_dir, 0);
    chk("simul_drop", drop_cnt, 3);

    // Three queued commands, then centre.
    press(5'b01000, 14, 14, 1'b0);
    press(5'b10000, 14, 14, 1'b0);
    press(5'b00001, 14, 14, 1'b0);
    chk("flush_pre_valid", bus.cmd_valid, 1);
    n_grst = 0;
    press(5'b00010, 14, 14, 1'b0);
    chk("flush_pulses", n_grst, 1);
    chk("flush_valid", bus.cmd_valid, 0);
    chk("flush_drop", drop_cnt, 3);

    // Reset with two queued commands and a debounce in flight.
    press(5'b00100, 14, 14, 1'b0);
    press(5'b01000, 14, 14, 1'b0);
    repeat (5) tick(5'b10000, 1'b0);
    do_reset();
    n_rise = 0;
    repeat (20) tick(5'b0, 1'b1);
    chk("rst_no_cmd", n_rise, 0);

    // Randomized traffic with one reset in the middle.
    for (int blk = 0; blk < 80; blk++) begin
      logic [4:0] b;
      int len;
      b = 5'($urandom_range(0, 31));
      if ($urandom_range(0, 7) != 0) b[BTN_CENTRE] = 1'b0;
      len = $urandom_range(1, 20);
      for (int c = 0; c < len; c++) tick(b, 1'($urandom_range(0, 1)));
      if (blk == 40) do_reset();
    end

    // Drop counter saturation: all four directions at once into a stalled queue.
    do_reset();
    repeat (80) press(5'b11101, 14, 14, 1'b0);
    chk("sat_drop", drop_cnt, 255);
    chk("sat_valid", bus.cmd_valid, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
